// File: rtl/div_issue_arbiter.sv
// rtl/div_issue_arbiter.sv - round-robin issue arbiter sharing one SRT divider between two execute pipes
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   reqN_valid/reqN_bus/reqN_ready   per-pipe request {use_mod, is_unsigned, x, y, tag}
//   flush[1:0]                       per-pipe kill of pending or in-flight operation
//   respN_valid/respN_bus/respN_ready per-pipe response {result, tag}
//   div_start/div_signed/div_use_mod/div_x/div_y  divider run request and operands
//   div_result/div_done              divider completion
//   busy                             an operation is in flight or awaiting consumption
module div_issue_arbiter #(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [TAG_W+65:0] req0_bus,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [TAG_W+65:0] req1_bus,
    output logic              req1_ready,
    input  logic [1:0]        flush,
    output logic              resp0_valid,
    output logic [TAG_W+31:0] resp0_bus,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    output logic [TAG_W+31:0] resp1_bus,
    input  logic              resp1_ready,
    output logic              div_start,
    output logic              div_signed,
    output logic              div_use_mod,
    output logic [31:0]       div_x,
    output logic [31:0]       div_y,
    input  logic [31:0]       div_result,
    input  logic              div_done,
    output logic              busy
);

    localparam int BIT_MOD = TAG_W + 65;
    localparam int BIT_UNS = TAG_W + 64;
    localparam int X_HI    = TAG_W + 63;
    localparam int X_LO    = TAG_W + 32;
    localparam int Y_HI    = TAG_W + 31;
    localparam int Y_LO    = TAG_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic             rr;
    logic             killed;
    logic             owner;
    logic             lat_use_mod;
    logic             lat_unsigned;
    logic [31:0]      lat_x;
    logic [31:0]      lat_y;
    logic [TAG_W-1:0] lat_tag;
    logic [31:0]      lat_result;

    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic [TAG_W+65:0] gbus;
    logic             owner_flush;
    logic             resp_hs;
    logic             in_run;
    logic             in_resp;

    always_comb begin
        in_run      = (state == ST_RUN);
        in_resp     = (state == ST_RESP);
        elig0       = req0_valid & ~flush[0];
        elig1       = req1_valid & ~flush[1];
        // rr names the pipe that wins a tie
        grant0      = (state == ST_IDLE) & elig0 & (~elig1 | ~rr);
        grant1      = (state == ST_IDLE) & elig1 & (~elig0 | rr);
        gbus        = grant1 ? req1_bus : req0_bus;
        owner_flush = flush[owner];
        resp_hs     = owner ? (resp1_valid & resp1_ready) : (resp0_valid & resp0_ready);
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign resp0_valid = in_resp & ~owner & ~flush[0];
    assign resp1_valid = in_resp &  owner & ~flush[1];
    assign resp0_bus   = (in_resp & ~owner) ? {lat_result, lat_tag} : '0;
    assign resp1_bus   = (in_resp &  owner) ? {lat_result, lat_tag} : '0;
    // Divider operands are only presented while running so idle outputs stay at zero
    assign div_start   = in_run;
    assign div_signed  = in_run & ~lat_unsigned;
    assign div_use_mod = in_run & lat_use_mod;
    assign div_x       = in_run ? lat_x : 32'd0;
    assign div_y       = in_run ? lat_y : 32'd0;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr           <= 1'b0;
            killed       <= 1'b0;
            owner        <= 1'b0;
            lat_use_mod  <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_x        <= 32'd0;
            lat_y        <= 32'd0;
            lat_tag      <= '0;
            lat_result   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 | grant1) begin
                        owner        <= grant1;
                        rr           <= ~grant1;
                        killed       <= 1'b0;
                        lat_use_mod  <= gbus[BIT_MOD];
                        lat_unsigned <= gbus[BIT_UNS];
                        lat_x        <= gbus[X_HI:X_LO];
                        lat_y        <= gbus[Y_HI:Y_LO];
                        lat_tag      <= gbus[TAG_W-1:0];
                        // Divide-by-zero is answered locally without touching the divider
                        if (gbus[Y_HI:Y_LO] == 32'd0) begin
                            lat_result <= gbus[BIT_MOD] ? gbus[X_HI:X_LO] : 32'hFFFF_FFFF;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // The divider is never aborted; a kill only drops its result
                    if (owner_flush) killed <= 1'b1;
                    if (div_done) begin
                        if (killed | owner_flush) begin
                            state <= ST_IDLE;
                        end else begin
                            lat_result <= div_result;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (owner_flush | resp_hs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_arbiter.sv
// tb/tb_div_issue_arbiter.sv - self-checking bench for div_issue_arbiter with transaction-level reference model
module tb_div_issue_arbiter;

    localparam int TW = 5;

    logic           clk;
    logic           reset;
    logic           req0_valid, req1_valid;
    logic [TW+65:0] req0_bus, req1_bus;
    logic           req0_ready, req1_ready;
    logic [1:0]     flush;
    logic           resp0_valid, resp1_valid;
    logic [TW+31:0] resp0_bus, resp1_bus;
    logic           resp0_ready, resp1_ready;
    logic           div_start, div_signed, div_use_mod;
    logic [31:0]    div_x, div_y, div_result;
    logic           div_done;
    logic           busy;

    div_issue_arbiter #(.TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_bus(req0_bus), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_bus(req1_bus), .req1_ready(req1_ready),
        .flush(flush),
        .resp0_valid(resp0_valid), .resp0_bus(resp0_bus), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_bus(resp1_bus), .resp1_ready(resp1_ready),
        .div_start(div_start), .div_signed(div_signed), .div_use_mod(div_use_mod),
        .div_x(div_x), .div_y(div_y), .div_result(div_result), .div_done(div_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: one outstanding transaction record
    bit          m_free, m_rr, m_wait, m_pend, m_killed, m_owner;
    bit          m_sgn, m_mod;
    logic [31:0] m_x, m_y, m_result;
    logic [TW-1:0] m_tag;

    // divider environment model
    bit dv_active, dv_just_done;
    int dv_cnt;
    int dv_lat = -1;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [TW+65:0] mkbus(input bit mod, input bit uns, input logic [31:0] x,
                                             input logic [31:0] y, input logic [TW-1:0] tag);
        return {mod, uns, x, y, tag};
    endfunction

    function automatic logic [31:0] ref_div(input bit sgn, input bit mod, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy, sr;
        if (y == 32'd0) return mod ? x : 32'hFFFF_FFFF;
        sx = x;
        sy = y;
        if (sgn) begin
            sr = mod ? (sx % sy) : (sx / sy);
            return sr;
        end
        return mod ? (x % y) : (x / y);
    endfunction

    function automatic logic [TW+65:0] rand_bus();
        logic [31:0] x, y;
        x = $urandom;
        case ($urandom_range(0, 3))
            0:       y = 32'd0;
            1:       y = $urandom_range(1, 50);
            default: y = $urandom;
        endcase
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) x = 32'd0;
        return mkbus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x, y, TW'($urandom));
    endfunction

    task automatic model_reset();
        m_free = 1; m_rr = 0; m_wait = 0; m_pend = 0; m_killed = 0; m_owner = 0;
    endtask

    // One clock: divider answers, outputs are compared against the model, model advances.
    task automatic cycle();
        bit e0, e1, g0, g1, gp;
        logic [TW+65:0] gb;
        @(negedge clk);
        div_done = 1'b0;
        if (reset) begin
            dv_active = 0;
        end else if (div_start) begin
            if (!dv_active) begin
                dv_active = 1;
                dv_cnt = (dv_lat >= 0) ? dv_lat : $urandom_range(0, 4);
            end
            if (dv_cnt == 0) begin
                div_done   = 1'b1;
                div_result = ref_div(div_signed, div_use_mod, div_x, div_y);
                dv_active  = 0;
            end else begin
                dv_cnt--;
            end
        end
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (dv_just_done) chk("div_gap", 64'(div_start), 64'(0));
            e0 = req0_valid & ~flush[0];
            e1 = req1_valid & ~flush[1];
            g0 = m_free & e0 & (!e1 || !m_rr);
            g1 = m_free & e1 & (!e0 || m_rr);
            chk("req0_ready", 64'(req0_ready), 64'(g0));
            chk("req1_ready", 64'(req1_ready), 64'(g1));
            chk("busy", 64'(busy), 64'(!m_free));
            chk("div_start", 64'(div_start), 64'(m_wait));
            chk("resp0_valid", 64'(resp0_valid), 64'(m_pend && m_owner == 0 && !flush[0]));
            chk("resp1_valid", 64'(resp1_valid), 64'(m_pend && m_owner == 1 && !flush[1]));
            if (m_wait)
                chk("div_ops", {div_signed, div_use_mod, div_x, div_y}, {m_sgn, m_mod, m_x, m_y});
            if (m_pend && !flush[m_owner])
                chk("resp_bus", 64'(m_owner ? resp1_bus : resp0_bus), 64'({m_result, m_tag}));
            if (m_free) begin
                if (g0 || g1) begin
                    gp = g1;
                    gb = gp ? req1_bus : req0_bus;
                    m_owner = gp; m_rr = !gp; m_free = 0; m_killed = 0;
                    {m_mod, m_sgn, m_x, m_y, m_tag} = gb;
                    m_sgn = !m_sgn;
                    m_result = ref_div(m_sgn, m_mod, m_x, m_y);
                    if (m_y == 0) m_pend = 1; else m_wait = 1;
                end
            end else if (m_wait) begin
                if (flush[m_owner]) m_killed = 1;
                if (div_done) begin
                    m_wait = 0;
                    if (m_killed) m_free = 1; else m_pend = 1;
                end
            end else if (m_pend) begin
                if (flush[m_owner] || (m_owner ? resp1_ready : resp0_ready)) begin
                    m_pend = 0; m_free = 1;
                end
            end
        end
        dv_just_done = div_done;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; flush = 2'b00;
        resp0_ready = 0; resp1_ready = 0;
        req0_bus = '0; req1_bus = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic wait_resp(input int p, input string name);
        for (int i = 0; i < 50; i++) begin
            if ((p == 0) ? resp0_valid : resp1_valid) break;
            cycle();
        end
        chk(name, 64'((p == 0) ? resp0_valid : resp1_valid), 64'(1));
    endtask

    task automatic consume(input int p, input logic [TW+31:0] exp, input string name);
        wait_resp(p, {name, "_seen"});
        chk(name, 64'((p == 0) ? resp0_bus : resp1_bus), 64'(exp));
        if (p == 0) resp0_ready = 1; else resp1_ready = 1;
        cycle();
        resp0_ready = 0; resp1_ready = 0;
    endtask

    logic [TW+31:0] held;

    initial begin
        div_done = 0; div_result = '0;
        dv_active = 0; dv_just_done = 0; dv_cnt = 0;
        model_reset();
        do_reset();

        // reset state: every output zero
        chk("rst_ctrl", 64'({req0_ready, req1_ready, resp0_valid, resp1_valid, div_start, busy, div_signed, div_use_mod}), 64'(0));
        chk("rst_div_ops", {div_x, div_y}, 64'(0));
        chk("rst_resp_bus", 64'({resp0_bus, resp1_bus}), 64'(0));

        // unsigned quotient and remainder on pipe0
        req0_valid = 1; req0_bus = mkbus(0, 1, 100, 7, 3); cycle(); req0_valid = 0;
        consume(0, {32'd14, 5'd3}, "t1_quot");
        req0_valid = 1; req0_bus = mkbus(1, 1, 100, 7, 3); cycle(); req0_valid = 0;
        consume(0, {32'd2, 5'd3}, "t1_mod");

        // round-robin after reset
        do_reset();
        req0_valid = 1; req0_bus = mkbus(0, 1, 50, 5, 1);
        req1_valid = 1; req1_bus = mkbus(0, 1, 60, 6, 2);
        #1 chk("rr_first", 64'({req1_ready, req0_ready}), 64'(2'b01));
        cycle(); req0_valid = 0;
        consume(0, {32'd10, 5'd1}, "rr_p0");
        #1 chk("rr_p1_next", 64'(req1_ready), 64'(1));
        cycle(); req1_valid = 0;
        consume(1, {32'd10, 5'd2}, "rr_p1");
        req0_valid = 1; req1_valid = 1; req0_bus = mkbus(1, 1, 50, 7, 4);
        #1 chk("rr_back_to_p0", 64'({req1_ready, req0_ready}), 64'(2'b01));
        cycle(); req0_valid = 0; req1_valid = 0;
        consume(0, {32'd1, 5'd4}, "rr_p0_again");

        // signed on pipe1
        req1_valid = 1; req1_bus = mkbus(0, 0, 32'hFFFF_FFF9, 2, 7); cycle(); req1_valid = 0;
        chk("t3_signed", 64'(div_signed), 64'(1));
        consume(1, {32'hFFFF_FFFD, 5'd7}, "t3_quot");
        req1_valid = 1; req1_bus = mkbus(1, 0, 32'hFFFF_FFF9, 2, 8); cycle(); req1_valid = 0;
        consume(1, {32'hFFFF_FFFF, 5'd8}, "t3_rem");

        // divide by zero: response one cycle after grant, divider untouched
        req0_valid = 1; req0_bus = mkbus(0, 1, 5, 0, 4); cycle(); req0_valid = 0;
        chk("t4_latency", 64'({resp0_valid, div_start}), 64'(2'b10));
        consume(0, {32'hFFFF_FFFF, 5'd4}, "t4_quot");
        req0_valid = 1; req0_bus = mkbus(1, 1, 5, 0, 5); cycle(); req0_valid = 0;
        chk("t4_latency_mod", 64'(resp0_valid), 64'(1));
        consume(0, {32'd5, 5'd5}, "t4_mod");

        // flush of the owner mid-run, pipe1 queued behind it
        dv_lat = 6;
        req0_valid = 1; req0_bus = mkbus(0, 1, 1000, 3, 9); cycle(); req0_valid = 0;
        cycle();
        flush = 2'b01; req1_valid = 1; req1_bus = mkbus(0, 1, 20, 4, 11); cycle(); flush = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (!div_start) break;
            cycle();
        end
        dv_lat = -1;
        chk("t5_no_resp0", 64'({resp0_valid, busy}), 64'(0));
        chk("t5_p1_grant", 64'(req1_ready), 64'(1));
        cycle(); req1_valid = 0;
        consume(1, {32'd5, 5'd11}, "t5_p1");

        // response held by backpressure while pipe0 waits
        req1_valid = 1; req1_bus = mkbus(1, 1, 23, 5, 13); cycle(); req1_valid = 0;
        wait_resp(1, "t6_seen");
        held = resp1_bus;
        req0_valid = 1; req0_bus = mkbus(0, 1, 9, 3, 14);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t6_hold", 64'({resp1_valid, resp1_bus, req0_ready, busy}), 64'({1'b1, 32'd3, 5'd13, 1'b0, 1'b1}));
        end
        chk("t6_held_eq", 64'(resp1_bus), 64'(held));
        resp1_ready = 1; cycle(); resp1_ready = 0;
        #1 chk("t6_p0_grant", 64'(req0_ready), 64'(1));
        cycle(); req0_valid = 0;
        consume(0, {32'd3, 5'd14}, "t6_p0");

        // reset in the middle of a run
        dv_lat = 6;
        req0_valid = 1; req0_bus = mkbus(0, 1, 77, 7, 2); cycle(); req0_valid = 0;
        cycle();
        reset = 1; cycle(); reset = 0;
        dv_lat = -1;
        chk("t7_after_reset", 64'({busy, div_start, resp0_valid}), 64'(0));

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            req0_valid  = ($urandom_range(0, 2) != 0);
            req1_valid  = ($urandom_range(0, 2) != 0);
            req0_bus    = rand_bus();
            req1_bus    = rand_bus();
            flush       = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            resp0_ready = 1'($urandom_range(0, 1));
            resp1_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        idle_inputs();
        resp0_ready = 1; resp1_ready = 1;
        for (int n = 0; n < 20; n++) cycle();
        chk("final_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_arbiter.md
Name: div_issue_arbiter

Overview:
Shares the single multi-cycle SRT divider between the two execute pipes. It arbitrates between per-pipe divide requests using round-robin priority and owns the divider start/hold handshake. It routes each result back to the issuing pipe with its tag, honours per-pipe flush, and short-circuits divide-by-zero without starting the divider. The block sits between the two execute stages and the divider core, with at most one operation in flight.

Parameters:
TAG_W, 5, width of the requester tag echoed back with the result.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req0_valid  in  1  pipe0 divide request
req0_bus  in  TAG_W+66  {use_mod, is_unsigned, x[31:0], y[31:0], tag}
req0_ready  out  1  pipe0 request accepted this cycle
req1_valid  in  1  pipe1 divide request
req1_bus  in  TAG_W+66  same layout as req0_bus
req1_ready  out  1  pipe1 request accepted this cycle
flush  in  2  per-pipe flush; bit i kills pipe i's pending or in-flight operation
resp0_valid  out  1  pipe0 result available
resp0_bus  out  32+TAG_W  {result[31:0], tag}
resp0_ready  in  1  pipe0 consumes result
resp1_valid  out  1  pipe1 result available
resp1_bus  out  32+TAG_W  same layout as resp0_bus
resp1_ready  in  1  pipe1 consumes result
div_start  out  1  divider run request; level, held high until div_done
div_signed  out  1  equals ~is_unsigned of the latched op
div_use_mod  out  1  selects remainder (1) or quotient (0)
div_x  out  32  dividend, stable while div_start=1
div_y  out  32  divisor, stable while div_start=1
div_result  in  32  divider result, valid when div_done=1
div_done  in  1  divider completion strobe
busy  out  1  high when the state is not IDLE

Behaviour:
- Reset: state=IDLE, rr=0 (pipe0 preferred), killed=0, owner=0, and operand, tag and result latches cleared. All valid/ready outputs, div_start and busy are 0. All data outputs are 0.
- Reset mid-operation: the block returns to IDLE and any in-flight result is lost. The divider shares the same reset.
- States: IDLE, RUN, RESP.
- IDLE, request eligibility: pipe i is eligible when reqi_valid=1 and flush[i]=0.
  - If both pipes are eligible, the pipe selected by rr wins.
  - The winner's reqi_ready=1 combinationally. Acceptance occurs when valid and ready are both high.
  - The loser's ready is 0. Ready is 0 for both pipes in RUN and RESP.
- IDLE, on grant:
  - Latch operands, tag and owner; clear killed; set rr to the non-granted pipe.
  - If y==0: latch result = use_mod ? x : 32'hFFFF_FFFF and go to RESP. div_start is never raised for this op.
  - Otherwise go to RUN.
- RUN:
  - div_start=1 with operands driven from the latches.
  - On div_done=1: latch div_result and go to RESP, or go to IDLE if killed is set (result dropped).
  - div_start is low in the cycle after div_done, so the divider always sees at least one idle cycle between operations.
- RESP:
  - resp{owner}_valid = ~flush[owner]; the bus holds the latched result and tag, stable until consumed.
  - On valid&ready: go to IDLE.
  - flush[owner]=1 in RESP: valid is masked in the same cycle, the response is discarded, and the next state is IDLE. Flush wins over a simultaneous ready.
- Flush in RUN: flush[owner] sets killed. The divider is never aborted: div_start stays high until div_done, then the result is discarded. flush of the non-owner pipe has no effect on the in-flight op.
- Latency for a grant in cycle T:
  - Nonzero divisor, done at cycle T+k: div_start rises at T+1 and resp_valid rises at T+k+1.
  - Zero divisor: resp_valid rises at T+1.
  - A new grant is possible no earlier than the cycle after the response handshake.
- Only one operation is outstanding in total; the non-owner's resp_valid is always 0.

Test Plan:
- Pipe0, unsigned x=100, y=7, use_mod=0, tag=3 -> resp0_bus={14, 3}. Repeat with use_mod=1 -> result 2. resp1_valid stays 0 throughout.
- After reset, both pipes valid in the same cycle -> pipe0 granted first, pipe1 granted after pipe0's response. Next simultaneous pair -> pipe0 granted again (rr points to pipe0 after the pipe1 grant).
- Pipe1, signed x=-7 (0xFFFFFFF9), y=2 -> quotient 0xFFFFFFFD. Same operands with use_mod=1 -> remainder 0xFFFFFFFF. div_signed=1 during RUN.
- Pipe0, x=5, y=0 -> div_start never asserted; resp0_valid rises 1 cycle after grant with 0xFFFFFFFF. With use_mod=1 -> result 5.
- Pipe0 op in RUN, flush=2'b01 pulsed mid-run -> div_start held until div_done, no resp0_valid, return to IDLE. A queued pipe1 request (20/4) is then granted and returns 5.
- resp1_ready held low 10 cycles with req0_valid=1 -> resp1_valid and resp1_bus stable, req0_ready=0, busy=1. Raising resp1_ready -> IDLE, and pipe0 is granted the following cycle.
